// File: rtl/register_dump_reader.sv
// Read-side sequencer: snapshots the register bank on start, then streams the words out
// in index order over a valid/ready handshake, followed by a one-cycle done pulse.
module register_dump_reader #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_REGS*WIDTH-1:0] regValues,
    input  logic                      outReady,
    output logic [WIDTH-1:0]          dataOut,
    output logic [IDX_W-1:0]          indexOut,
    output logic                      dataValid,
    output logic                      lastOut,
    output logic                      busy,
    output logic                      done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e                    state_q;
    logic [NUM_REGS*WIDTH-1:0] snap_q;
    logic [IDX_W-1:0]          next_idx;

    assign next_idx = indexOut + 1'b1;

    // All outputs are registers; outReady only steers next-state, never an output directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            dataOut   <= '0;
            indexOut  <= '0;
            dataValid <= 1'b0;
            lastOut   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        snap_q    <= regValues;
                        dataOut   <= regValues[WIDTH-1:0];
                        indexOut  <= '0;
                        dataValid <= 1'b1;
                        lastOut   <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StSend;
                    end
                end
                StSend: begin
                    // dataValid is always high here, so outReady alone marks a transfer.
                    if (outReady) begin
                        if (lastOut) begin
                            dataValid <= 1'b0;
                            lastOut   <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            indexOut <= next_idx;
                            dataOut  <= snap_q[next_idx*WIDTH +: WIDTH];
                            lastOut  <= (next_idx == LastIdx);
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump_reader.sv
// Bench for register_dump_reader: dump-position model checked every cycle, plus directed
// scenarios with hand-computed word sequences and event counts.
module tb_register_dump_reader;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              outReady = 1'b1;
    logic [N*W-1:0]    regValues = '0;
    logic [W-1:0]      dataOut;
    logic [IW-1:0]     indexOut;
    logic              dataValid;
    logic              lastOut;
    logic              busy;
    logic              done;

    register_dump_reader #(
        .NUM_REGS(N),
        .WIDTH   (W),
        .IDX_W   (IW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .regValues(regValues),
        .outReady (outReady),
        .dataOut  (dataOut),
        .indexOut (indexOut),
        .dataValid(dataValid),
        .lastOut  (lastOut),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_pos = -1 idle, 0..N-1 presenting word m_pos, N = done cycle.
    int           m_pos = -1;
    logic [W-1:0] m_snap [N];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pos = -1;
        end else if (m_pos < 0) begin
            if (start) begin
                for (int k = 0; k < N; k++) m_snap[k] = regValues[k*W +: W];
                m_pos = 0;
            end
        end else if (m_pos < N) begin
            if (outReady) m_pos++;
        end else begin
            m_pos = -1;
        end
    end

    logic       e_valid;
    logic [9:0] e_vec;
    logic [9:0] a_vec;

    always @(negedge clock) begin
        e_valid = (m_pos >= 0) && (m_pos < N);
        e_vec   = {m_pos >= 0, e_valid, m_pos == N, m_pos == N - 1, 6'b0};
        if (e_valid) e_vec[5:0] = {m_snap[m_pos], IW'(m_pos)};
        a_vec   = {busy, dataValid, done, lastOut, 6'b0};
        if (dataValid) a_vec[5:0] = {dataOut, indexOut};
        check("cycle", 32'(a_vec), 32'(e_vec));
    end

    // Transfer / done monitor
    int           cyc = 0;
    int           last_xfer_cyc = 0;
    int           done_cyc = 0;
    int           done_count = 0;
    int           xfer_idx[$];
    logic [W-1:0] xfer_data[$];
    int           xfer0_cyc[$];

    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            if (dataValid && outReady) begin
                xfer_idx.push_back(int'(indexOut));
                xfer_data.push_back(dataOut);
                last_xfer_cyc = cyc;
                if (indexOut == '0) xfer0_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc;
                done_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        xfer_idx.delete();
        xfer_data.delete();
        xfer0_cyc.delete();
        done_count = 0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            if (!busy) return;
            tick();
        end
        check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_word(input string name, input logic [3:0] d, input logic [1:0] i,
                               input logic l);
        check(name, 32'({dataValid, dataOut, indexOut, lastOut}), 32'({1'b1, d, i, l}));
    endtask

    task automatic expect_seq(input string name, input logic [15:0] words);
        check({name, "_count"}, 32'(xfer_data.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < xfer_data.size()) begin
                check({name, "_data"}, 32'(xfer_data[k]), 32'(words[k*4 +: 4]));
                check({name, "_idx"}, 32'(xfer_idx[k]), 32'(k));
            end
        end
    endtask

    int pat[8] = '{0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        #1 reset = 1'b1;
        #2;
        check("reset_outputs", 32'({dataOut, indexOut, dataValid, lastOut, busy, done}), 32'd0);
        tick();
        tick();
        @(negedge clock);
        reset     = 1'b0;
        regValues = 16'hA5C3;
        outReady  = 1'b1;

        // Plain dump
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_word("t1_w0", 4'h3, 2'd0, 1'b0);
        tick();
        expect_word("t1_w1", 4'hC, 2'd1, 1'b0);
        tick();
        expect_word("t1_w2", 4'h5, 2'd2, 1'b0);
        tick();
        expect_word("t1_w3", 4'hA, 2'd3, 1'b1);
        tick();
        check("t1_done", 32'({done, dataValid, busy}), 32'b101);
        tick();
        check("t1_idle", 32'({done, busy}), 32'd0);

        // Back-pressure
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 30 && busy; c++) begin
            outReady = pat[c % 8][0];
            tick();
        end
        outReady = 1'b1;
        wait_idle("t2");
        expect_seq("t2", 16'hA5C3);
        check("t2_done_count", 32'(done_count), 32'd1);
        check("t2_done_lag", 32'(done_cyc - last_xfer_cyc), 32'd1);

        // Snapshot isolation
        clear_log();
        regValues = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        regValues = 16'hFFFF;
        wait_idle("t3a");
        expect_seq("t3a", 16'h1234);
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t3b");
        expect_seq("t3b", 16'hFFFF);

        // Start ignored in cycles 2 and 5
        clear_log();
        regValues = 16'hA5C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t4");
        tick();
        tick();
        check("t4_xfers", 32'(xfer_idx.size()), 32'd4);
        check("t4_dones", 32'(done_count), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);

        // Continuous start for 20 cycles: dumps at edges 1, 7, 13, 19
        clear_log();
        start = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        wait_idle("t5");
        check("t5_dumps", 32'(xfer0_cyc.size()), 32'd4);
        check("t5_dones", 32'(done_count), 32'd4);
        for (int k = 1; k < xfer0_cyc.size(); k++)
            check("t5_spacing", 32'(xfer0_cyc[k] - xfer0_cyc[k-1]), 32'd6);

        // Async reset while index 2 is pending
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        outReady = 1'b0;
        expect_word("t6_w2", 4'h5, 2'd2, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("t6_async", 32'({dataOut, indexOut, dataValid, lastOut, busy, done}), 32'd0);
        tick();
        @(negedge clock);
        reset    = 1'b0;
        outReady = 1'b1;
        tick();
        tick();
        check("t6_no_done", 32'({done_count[3:0], busy}), 32'd0);
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t6");
        expect_seq("t6_redump", 16'hA5C3);
        check("t6_done_count", 32'(done_count), 32'd1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
